// File: rtl/alu_pkg.sv
// Shared types for the ALU execution unit: opcode enum, bubble encoding
// and the result-queue entry layout.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int ROB_W  = 3;

    typedef enum logic [3:0] {
        OP_ADD    = 4'b0000,
        OP_SUB    = 4'b0001,
        OP_AND    = 4'b0010,
        OP_OR     = 4'b0011,
        OP_XOR    = 4'b0100,
        OP_SLL    = 4'b0101,
        OP_SRL    = 4'b0110,
        OP_SRA    = 4'b0111,
        OP_SLT    = 4'b1000,
        OP_SLTU   = 4'b1001,
        OP_PASS   = 4'b1010,
        OP_BUBBLE = 4'b1111
    } alu_op_t;

    localparam logic [3:0] ALU_BUBBLE = 4'b1111;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [ROB_W-1:0]  rob;
    } rq_entry_t;

endpackage

// File: rtl/alu_exec_unit_if.sv
// Issue-side and CDB-side signals of the ALU execution unit.
// master: reservation station plus CDB arbiter; slave: the execution unit.
interface alu_exec_unit_if #(
    parameter int WIDTH   = 31,
    parameter int ROB     = 2,
    parameter int C_WIDTH = 3
);
    logic signed [WIDTH:0] src1;
    logic signed [WIDTH:0] src2;
    logic [C_WIDTH:0]      instrInfo;
    logic [ROB:0]          instrRob;
    logic                  execute;
    logic                  cdbGrant;
    logic                  cdbReq;
    logic [WIDTH:0]        cdbResult;
    logic [ROB:0]          cdbRob;

    modport master (
        output src1, src2, instrInfo, instrRob, cdbGrant,
        input  execute, cdbReq, cdbResult, cdbRob
    );

    modport slave (
        input  src1, src2, instrInfo, instrRob, cdbGrant,
        output execute, cdbReq, cdbResult, cdbRob
    );
endinterface

// File: rtl/alu_core.sv
// Purely combinational ALU: (src1, src2, op) -> result.
// Shifts use the low five bits of src2; reserved opcodes and the bubble give 0.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH   = 31,
    parameter int C_WIDTH = 3
) (
    input  logic signed [WIDTH:0] src1,
    input  logic signed [WIDTH:0] src2,
    input  logic [C_WIDTH:0]      op,
    output logic [WIDTH:0]        result
);

    logic [4:0] shamt;
    logic       lessSigned;
    logic       lessUnsigned;

    assign shamt        = src2[4:0];
    assign lessSigned   = (src1 < src2);
    assign lessUnsigned = ($unsigned(src1) < $unsigned(src2));

    // Opcode decode; arithmetic wraps naturally at the datapath width
    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = src1 + src2;
            OP_SUB:  result = src1 - src2;
            OP_AND:  result = src1 & src2;
            OP_OR:   result = src1 | src2;
            OP_XOR:  result = src1 ^ src2;
            OP_SLL:  result = src1 << shamt;
            OP_SRL:  result = $unsigned(src1) >> shamt;
            OP_SRA:  result = src1 >>> shamt;
            OP_SLT:  result = {{WIDTH{1'b0}}, lessSigned};
            OP_SLTU: result = {{WIDTH{1'b0}}, lessUnsigned};
            OP_PASS: result = src2;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU functional unit behind the ALU reservation station.
// Captures issued ops, computes them in alu_core, buffers results in a small
// in-order queue and requests the CDB with a req/grant handshake.
// Optional feature macro: ALU_BYPASS_EN -- when defined, an op arriving at an
// empty queue is offered to the CDB in the same cycle and skips the queue if granted.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH    = 31,
    parameter int ROB      = 2,
    parameter int C_WIDTH  = 3,
    parameter int RQ_DEPTH = 2
) (
    input logic            clk,
    input logic            globalReset,
    input logic            clear,
    alu_exec_unit_if.slave bus
);

    localparam int PTR_W = $clog2(RQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic              inValid_q;
    logic [PTR_W-1:0]  headPtr;
    logic [PTR_W-1:0]  tailPtr;
    logic [CNT_W-1:0]  count;
    rq_entry_t         rqMem [RQ_DEPTH];

    logic [WIDTH:0]    aluResult;
    logic [WIDTH:0]    headResult;
    logic [ROB:0]      headRob;
    logic [CNT_W:0]    occupancy;
    logic              consume;
    logic              qEmpty;
    logic              bypassHit;
    logic              push;
    logic              pop;

    alu_core #(
        .WIDTH   (WIDTH),
        .C_WIDTH (C_WIDTH)
    ) u_alu_core (
        .src1   (bus.src1),
        .src2   (bus.src2),
        .op     (bus.instrInfo),
        .result (aluResult)
    );

    assign consume    = inValid_q && (bus.instrInfo != ALU_BUBBLE);
    assign qEmpty     = (count == '0);
    assign headResult = rqMem[headPtr].result;
    assign headRob    = rqMem[headPtr].rob;

`ifdef ALU_BYPASS_EN
    assign bypassHit = qEmpty && consume;
`else
    assign bypassHit = 1'b0;
`endif

    // A granted bypass result has already left on the CDB, so it is not queued
    assign pop  = !qEmpty && bus.cdbGrant;
    assign push = consume && !(bypassHit && bus.cdbGrant);

    // Issue permission counts the queue plus the op that may already be in the
    // station register; a pop in the same cycle earns no credit
    assign occupancy   = {1'b0, count} + {{CNT_W{1'b0}}, inValid_q};
    assign bus.execute = (occupancy < (CNT_W + 1)'(RQ_DEPTH));

    // CDB drive: queue head first, otherwise the bypassed ALU result, otherwise idle zeros
    always_comb begin
        bus.cdbReq    = 1'b0;
        bus.cdbResult = '0;
        bus.cdbRob    = '0;
        if (!qEmpty) begin
            bus.cdbReq    = 1'b1;
            bus.cdbResult = headResult;
            bus.cdbRob    = headRob;
        end else if (bypassHit) begin
            bus.cdbReq    = 1'b1;
            bus.cdbResult = aluResult;
            bus.cdbRob    = bus.instrRob;
        end
    end

    // Queue storage is not reset; count and pointers alone decide what is valid
    always_ff @(posedge clk) begin
        if (push) begin
            rqMem[tailPtr] <= '{result: aluResult, rob: bus.instrRob};
        end
    end

    // Capture flag, pointers and occupancy; reset and flush both drop everything in flight
    always_ff @(posedge clk) begin
        if (globalReset || clear) begin
            inValid_q <= 1'b0;
            headPtr   <= '0;
            tailPtr   <= '0;
            count     <= '0;
        end else begin
            inValid_q <= bus.execute;
            if (push) begin
                tailPtr <= tailPtr + PTR_W'(1);
            end
            if (pop) begin
                headPtr <= headPtr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit.
// A behavioural model (plain arithmetic plus a queue of expected CDB writes)
// predicts every cycle's CDB outputs and issue permission; directed scenarios
// are followed by randomized traffic with random grants and flushes.
module tb_alu_exec_unit;

    localparam int RQ_DEPTH = 2;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  rob;
    } op_t;

    typedef struct {
        logic [31:0] res;
        logic [2:0]  rob;
    } wr_t;

    logic clk;
    logic globalReset;
    logic clear;

    alu_exec_unit_if #(.WIDTH(31), .ROB(2), .C_WIDTH(3)) bus ();

    alu_exec_unit #(
        .WIDTH    (31),
        .ROB      (2),
        .C_WIDTH  (3),
        .RQ_DEPTH (RQ_DEPTH)
    ) dut (
        .clk         (clk),
        .globalReset (globalReset),
        .clear       (clear),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int  checks = 0;
    int  passes = 0;

    wr_t modelQ[$];
    op_t pending[$];
    wr_t obsWrites[$];
    op_t stOp;
    bit  stValid;

    logic        lastReq;
    logic        lastExec;
    logic [31:0] lastRes;
    logic [2:0]  lastRob;

    // Reference ALU written directly from the opcode table
    function automatic logic [31:0] refAlu(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        int unsigned sh;
        sh = b % 32;
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << sh;
            4'd6:    return a >> sh;
            4'd7:    return 32'($signed(a) >>> sh);
            4'd8:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9:    return (a < b) ? 32'd1 : 32'd0;
            4'd10:   return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic op_t mkOp(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [2:0] rob);
        op_t o;
        o.op = op; o.a = a; o.b = b; o.rob = rob;
        return o;
    endfunction

    function automatic op_t bubbleOp();
        return mkOp(4'hF, $urandom, $urandom, 3'($urandom_range(0, 7)));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic driveStation();
        bus.src1      = stOp.a;
        bus.src2      = stOp.b;
        bus.instrInfo = stOp.op;
        bus.instrRob  = stOp.rob;
    endtask

    // The station moves its register only when execute was high at the edge
    task automatic loadStation();
        if (pending.size() > 0) stOp = pending.pop_front();
        else                    stOp = bubbleOp();
    endtask

    // One clock cycle: apply controls, check outputs at negedge, advance model at posedge
    task automatic applyStimulus(input bit grant, input bit clr, input bit rst);
        bit          consumed, bypassNow, bypassTaken, expReq, expExec;
        logic [31:0] aluVal, expRes;
        logic [2:0]  expRob;
        wr_t         w;

        bus.cdbGrant = grant;
        clear        = clr;
        globalReset  = rst;

        consumed    = stValid && (stOp.op != 4'hF);
        aluVal      = refAlu(stOp.op, stOp.a, stOp.b);
        bypassNow   = 1'b0;
        bypassTaken = 1'b0;
`ifdef ALU_BYPASS_EN
        if (modelQ.size() == 0 && consumed) bypassNow = 1'b1;
`endif
        expReq = (modelQ.size() != 0) || bypassNow;
        expRes = 32'd0;
        expRob = 3'd0;
        if (modelQ.size() != 0) begin
            expRes = modelQ[0].res;
            expRob = modelQ[0].rob;
        end else if (bypassNow) begin
            expRes = aluVal;
            expRob = stOp.rob;
        end
        expExec = (modelQ.size() + int'(stValid)) < RQ_DEPTH;

        @(negedge clk);
        lastReq  = bus.cdbReq;
        lastRes  = bus.cdbResult;
        lastRob  = bus.cdbRob;
        lastExec = bus.execute;
        checkOutput("cdbReq", {31'd0, lastReq}, {31'd0, expReq});
        checkOutput("cdbResult", lastRes, expRes);
        checkOutput("cdbRob", {29'd0, lastRob}, {29'd0, expRob});
        checkOutput("execute", {31'd0, lastExec}, {31'd0, expExec});
        if (lastReq === 1'b1 && grant && !rst && !clr) begin
            w.res = lastRes;
            w.rob = lastRob;
            obsWrites.push_back(w);
        end

        @(posedge clk);
        if (rst || clr) begin
            modelQ.delete();
            stValid = 1'b0;
            stOp    = bubbleOp();
        end else begin
            if (expReq && grant) begin
                if (modelQ.size() != 0) void'(modelQ.pop_front());
                else                    bypassTaken = 1'b1;
            end
            if (consumed && !bypassTaken) begin
                w.res = aluVal;
                w.rob = stOp.rob;
                modelQ.push_back(w);
            end
            stValid = expExec;
            if (expExec) loadStation();
        end
        #1;
        driveStation();
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check(tag, obs, exp);
    endtask

    task automatic runCycles(input int n, input bit grant);
        for (int i = 0; i < n; i++) applyStimulus(grant, 1'b0, 1'b0);
    endtask

    initial begin
        globalReset   = 1'b1;
        clear         = 1'b0;
        bus.cdbGrant  = 1'b0;
        stOp          = bubbleOp();
        stValid       = 1'b0;
        driveStation();
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Single ADD: 5 + -7 = -2 on tag 3
        obsWrites.delete();
        pending.push_back(mkOp(4'd0, 32'd5, -32'sd7, 3'd3));
        runCycles(5, 1'b1);
        check("add_count", obsWrites.size(), 32'd1);
        if (obsWrites.size() > 0) begin
            check("add_value", obsWrites[0].res, 32'hFFFF_FFFE);
            check("add_rob", {29'd0, obsWrites[0].rob}, 32'd3);
        end

        // Backpressure: queue fills, station holds SRA while execute is low
        obsWrites.delete();
        pending.push_back(mkOp(4'd1, 32'd100, 32'd1, 3'd1));
        pending.push_back(mkOp(4'd7, -32'sd16, 32'd2, 3'd2));
        pending.push_back(mkOp(4'd9, 32'd1, 32'hFFFF_FFFF, 3'd4));
        runCycles(7, 1'b0);
        check("bp_execute_low", {31'd0, lastExec}, 32'd0);
        runCycles(8, 1'b1);
        check("bp_count", obsWrites.size(), 32'd3);
        if (obsWrites.size() == 3) begin
            check("bp_rob0", {29'd0, obsWrites[0].rob}, 32'd1);
            check("bp_rob1", {29'd0, obsWrites[1].rob}, 32'd2);
            check("bp_rob2", {29'd0, obsWrites[2].rob}, 32'd4);
            check("bp_sub", obsWrites[0].res, 32'd99);
            check("bp_sra", obsWrites[1].res, 32'hFFFF_FFFC);
            check("bp_sltu", obsWrites[2].res, 32'd1);
        end

        // Explicit bubble is never enqueued
        obsWrites.delete();
        pending.push_back(mkOp(4'hF, 32'd7, 32'd9, 3'd5));
        runCycles(4, 1'b1);
        check("bubble_writes", obsWrites.size(), 32'd0);

        // Push and pop in the same cycle: head becomes the new op
        pending.push_back(mkOp(4'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 3'd6));
        pending.push_back(mkOp(4'd10, 32'd0, 32'h1234_5000, 3'd7));
        runCycles(2, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        check("pushpop_req", {31'd0, lastReq}, 32'd1);
        check("pushpop_rob", {29'd0, lastRob}, 32'd7);
        check("pushpop_val", lastRes, 32'h1234_5000);
        runCycles(4, 1'b1);

        // Flush mid-handshake with another op in flight
        obsWrites.delete();
        pending.push_back(mkOp(4'd3, 32'd1, 32'd2, 3'd5));
        pending.push_back(mkOp(4'd4, 32'd3, 32'd6, 3'd6));
        runCycles(2, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        runCycles(5, 1'b1);
        check("flush_writes", obsWrites.size(), 32'd0);

        // Reset with two queued entries
        pending.push_back(mkOp(4'd0, 32'd1, 32'd1, 3'd1));
        pending.push_back(mkOp(4'd0, 32'd2, 32'd2, 3'd2));
        runCycles(4, 1'b0);
        check("prereset_req", {31'd0, lastReq}, 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        check("reset_req", {31'd0, lastReq}, 32'd0);
        check("reset_res", lastRes, 32'd0);
        check("reset_rob", {29'd0, lastRob}, 32'd0);
        check("reset_exec", {31'd0, lastExec}, 32'd1);

        // Randomized traffic with random grants and rare flushes
        for (int i = 0; i < 400; i++) begin
            if (pending.size() < 2) begin
                pending.push_back(mkOp(4'($urandom_range(0, 15)),
                                       ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
                                       ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
                                       3'($urandom_range(0, 7))));
            end
            applyStimulus(1'($urandom_range(0, 2) != 0), ($urandom_range(0, 39) == 0), 1'b0);
        end
        runCycles(6, 1'b1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
